wb16_fetch: RTL and testbench
=============================

# wb16_fetch

Wishbone-style bus initiator that fetches 32-bit words over the 16-bit read-only instruction bus. Each core fetch request becomes two consecutive halfword reads: low halfword first, then high halfword. The halfwords are assembled little-endian into one instruction word. The block sits between the processor's fetch stage and the boot ROM / instruction bus, and includes a watchdog that aborts a stalled bus cycle.

## Interface
Parameters:
- AW, 8, byte-address width of the instruction bus (bus carries bits AW-1:1)
- TIMEOUT, 15, maximum consecutive un-acked cycles per halfword before abort (≥1)

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- reset_i  in  1  reset; asynchronous, active-high
- fetch_req_i  in  1  core requests a fetch
- fetch_adr_i  in  AW-2 (AW-1:2)  word address of request
- fetch_ready_o  out  1  block idle; request accepted when fetch_req_i & fetch_ready_o at a rising edge
- fetch_valid_o  out  1  one-cycle pulse; fetch_dat_o/fetch_err_o valid
- fetch_dat_o  out  32  assembled word {high halfword, low halfword}
- fetch_err_o  out  1  with fetch_valid_o: bus timeout occurred
- m_adr_o  out  AW-1 (AW-1:1)  halfword address
- m_cyc_o  out  1  bus cycle in progress
- m_stb_o  out  1  strobe
- m_we_o  out  1  constant 0
- m_dat_i  in  16  read data
- m_ack_i  in  1  acknowledge; may be combinational from m_stb_o

## Operation
- States: IDLE, LO, HI, DONE. fetch_ready_o = (state == IDLE).
- IDLE:
  - On accepted request, latch fetch_adr_i and clear the watchdog count.
  - Set m_adr_o = {adr, 1'b0}, raise m_cyc_o and m_stb_o, then go to LO.
- LO, m_ack_i = 1:
  - Capture m_dat_i into the low half.
  - Set m_adr_o = {adr, 1'b1}, clear the watchdog count, go to HI.
  - m_cyc_o and m_stb_o stay high.
- HI, m_ack_i = 1:
  - Capture m_dat_i into the high half.
  - Drop m_cyc_o and m_stb_o.
  - Load fetch_dat_o, set fetch_err_o = 0, go to DONE.
- LO/HI, m_ack_i = 0:
  - Increment the watchdog count.
  - If the count reaches TIMEOUT, drop m_cyc_o and m_stb_o, set fetch_dat_o = 0 and fetch_err_o = 1, go to DONE. The second halfword is not attempted after a low-half timeout.
- DONE: fetch_valid_o = 1 for exactly this cycle, then go to IDLE.
- fetch_req_i outside IDLE is ignored, not queued. m_ack_i outside LO/HI is ignored.
- fetch_dat_o and fetch_err_o hold their values until the next DONE.
- m_adr_o holds its last value when idle.
- Watchdog count width: clog2(TIMEOUT+1). It saturates only by the state exit.

## Timing
- Reset values (applied immediately on reset_i, also mid-transfer):
  - state IDLE; fetch_ready_o 1.
  - fetch_valid_o 0, fetch_err_o 0, fetch_dat_o 0.
  - m_cyc_o 0, m_stb_o 0, m_adr_o 0, m_we_o 0.
  - A transfer in progress is abandoned and no valid pulse is emitted.
- Zero-wait slave, request accepted at edge E0:
  - LO cycle E0–E1, HI cycle E1–E2.
  - fetch_valid_o high E2–E3; fetch_ready_o high from E3.
  - Minimum request-to-request spacing: 3 cycles of busy plus 1 idle.
- Each wait state adds one cycle to the affected halfword.
- Timeout: m_stb_o stays high for exactly TIMEOUT cycles on the stalled halfword, then DONE.
- fetch_valid_o and fetch_dat_o are registered outputs. m_* outputs are registered.

## Test plan
- Reset then idle:
  - Stimulus: assert reset_i mid-cycle.
  - Response: all outputs take reset values without waiting for a clock; fetch_ready_o = 1.
- Zero-wait fetch:
  - Stimulus: ROM model holds halfwords 0x0113, 0x0000 at halfword addresses 0 and 1; request adr 0.
  - Response: m_adr_o sequence 0 then 1; fetch_valid_o pulses 2 cycles after acceptance with fetch_dat_o = 0x00000113, fetch_err_o = 0.
- Back-to-back fetches:
  - Stimulus: halfwords 0x01B7, 0x0010, 0x0113, 0x0011 at addresses 2–5; request word 1, then word 2 as soon as fetch_ready_o returns.
  - Response: results 0x001001B7 then 0x00110113; fetch_req_i held high during busy cycles causes no extra bus cycles.
- Wait states:
  - Stimulus: slave delays ack by 3 cycles on LO and 1 cycle on HI.
  - Response: m_cyc_o stays continuously high; valid arrives 6 cycles after acceptance with correct data.
- Timeout, TIMEOUT = 4:
  - Stimulus: no ack on HI.
  - Response: m_stb_o high for exactly 4 HI cycles, then dropped; fetch_valid_o = 1, fetch_err_o = 1, fetch_dat_o = 0; next request proceeds normally.
- Reset mid-transfer:
  - Stimulus: assert reset_i during HI.
  - Response: m_cyc_o and m_stb_o drop at once; no fetch_valid_o pulse; a fresh request after reset returns correct data.

Source files
------------

// File: rtl/wb16_fetch_if.sv
// wb16_fetch_if: fetch-side handshake and 16-bit instruction bus signals of wb16_fetch
interface wb16_fetch_if #(parameter int AW = 8);
   logic          fetch_req_i;
   logic [AW-3:0] fetch_adr_i;
   logic          fetch_ready_o;
   logic          fetch_valid_o;
   logic [31:0]   fetch_dat_o;
   logic          fetch_err_o;
   logic [AW-2:0] m_adr_o;
   logic          m_cyc_o;
   logic          m_stb_o;
   logic          m_we_o;
   logic [15:0]   m_dat_i;
   logic          m_ack_i;
   modport master (
      input  fetch_req_i, fetch_adr_i, m_dat_i, m_ack_i,
      output fetch_ready_o, fetch_valid_o, fetch_dat_o, fetch_err_o,
             m_adr_o, m_cyc_o, m_stb_o, m_we_o
   );
   modport slave (
      output fetch_req_i, fetch_adr_i, m_dat_i, m_ack_i,
      input  fetch_ready_o, fetch_valid_o, fetch_dat_o, fetch_err_o,
             m_adr_o, m_cyc_o, m_stb_o, m_we_o
   );
endinterface

// File: rtl/wb16_fetch.sv
// wb16_fetch: fetches a 32-bit word as two 16-bit bus reads (low then high) with a stall watchdog
module wb16_fetch #(
   parameter int AW      = 8,
   parameter int TIMEOUT = 15
) (
   input logic          clk_i,
   input logic          reset_i,
   wb16_fetch_if.master bus
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
   state_t        state, state_n;
   logic [AW-3:0] adr, adr_n;
   logic [15:0]   lo, lo_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [AW-2:0] m_adr_n;
   logic          cyc_n, err_n, timeout;
   logic [31:0]   dat_n;
   assign timeout           = cnt == CW'(TIMEOUT - 1);
   assign bus.fetch_ready_o = state == IDLE;
   assign bus.m_we_o        = 1'b0;
   always_comb begin
      state_n = state;
      adr_n   = adr;
      lo_n    = lo;
      cnt_n   = cnt;
      m_adr_n = bus.m_adr_o;
      cyc_n   = bus.m_cyc_o;
      dat_n   = bus.fetch_dat_o;
      err_n   = bus.fetch_err_o;
      case (state)
         IDLE: if (bus.fetch_req_i) begin
            adr_n   = bus.fetch_adr_i;
            cnt_n   = '0;
            m_adr_n = {bus.fetch_adr_i, 1'b0};
            cyc_n   = 1'b1;
            state_n = LO;
         end
         LO, HI: if (bus.m_ack_i) begin
            cnt_n = '0;
            if (state == LO) begin
               lo_n    = bus.m_dat_i;
               m_adr_n = {adr, 1'b1};
               state_n = HI;
            end else begin
               cyc_n   = 1'b0;
               dat_n   = {bus.m_dat_i, lo};
               err_n   = 1'b0;
               state_n = DONE;
            end
         end else if (timeout) begin
            // abandon the whole fetch; a stalled low half never tries the high half
            cyc_n   = 1'b0;
            dat_n   = '0;
            err_n   = 1'b1;
            state_n = DONE;
         end else begin
            cnt_n = cnt + 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         state             <= IDLE;
         adr               <= '0;
         lo                <= '0;
         cnt               <= '0;
         bus.m_adr_o       <= '0;
         bus.m_cyc_o       <= 1'b0;
         bus.m_stb_o       <= 1'b0;
         bus.fetch_dat_o   <= '0;
         bus.fetch_err_o   <= 1'b0;
         bus.fetch_valid_o <= 1'b0;
      end else begin
         state             <= state_n;
         adr               <= adr_n;
         lo                <= lo_n;
         cnt               <= cnt_n;
         bus.m_adr_o       <= m_adr_n;
         bus.m_cyc_o       <= cyc_n;
         bus.m_stb_o       <= cyc_n;
         bus.fetch_dat_o   <= dat_n;
         bus.fetch_err_o   <= err_n;
         bus.fetch_valid_o <= state_n == DONE;
      end
endmodule

// File: tb/tb_wb16_fetch.sv
// tb_wb16_fetch: directed checks of wb16_fetch against a ROM slave with programmable wait states
module tb_wb16_fetch;
   logic clk_i   = 1'b0;
   logic reset_i = 1'b0;
   int   errors  = 0;
   int   checks  = 0;
   logic [15:0] rom [128];
   int   lo_wait = 0;
   int   hi_wait = 0;
   int   wcnt = 0, vcnt = 0, acks = 0, cyc_cyc = 0, stb_hi = 0;

   wb16_fetch_if #(.AW(8)) bus();
   wb16_fetch #(.AW(8), .TIMEOUT(4)) dut (.clk_i(clk_i), .reset_i(reset_i), .bus(bus.master));

   always #5 clk_i = ~clk_i;

   assign bus.m_dat_i = rom[bus.m_adr_o];
   assign bus.m_ack_i = bus.m_stb_o && (wcnt >= (bus.m_adr_o[0] ? hi_wait : lo_wait));

   always @(posedge clk_i) begin
      wcnt <= (bus.m_stb_o && !bus.m_ack_i) ? wcnt + 1 : 0;
      if (bus.fetch_valid_o) vcnt <= vcnt + 1;
      if (bus.m_ack_i) acks <= acks + 1;
      if (bus.m_cyc_o) cyc_cyc <= cyc_cyc + 1;
      if (bus.m_stb_o && bus.m_adr_o[0]) stb_hi <= stb_hi + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // call at a negedge with the block idle; returns one negedge after the valid pulse
   task automatic fetch(input logic [5:0] wa, input logic [31:0] exp_d, input logic exp_e,
                        input int exp_lat, input bit hold);
      int n;
      bus.fetch_req_i = 1'b1;
      bus.fetch_adr_i = wa;
      @(negedge clk_i);
      if (!hold) bus.fetch_req_i = 1'b0;
      n = 0;
      while (!bus.fetch_valid_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      bus.fetch_req_i = 1'b0;
      chk("latency", n, exp_lat);
      chk("fetch_dat", bus.fetch_dat_o, exp_d);
      chk("fetch_err", bus.fetch_err_o, exp_e);
      chk("cyc_at_valid", bus.m_cyc_o, 0);
      @(negedge clk_i);
      chk("ready_after", bus.fetch_ready_o, 1);
      chk("valid_one_cycle", bus.fetch_valid_o, 0);
      chk("dat_hold", bus.fetch_dat_o, exp_d);
   endtask

   initial begin
      int a0, c0, s0, v0;
      for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
      rom[0]  = 16'h0113; rom[1]  = 16'h0000;
      rom[2]  = 16'h01B7; rom[3]  = 16'h0010;
      rom[4]  = 16'h0113; rom[5]  = 16'h0011;
      rom[6]  = 16'h1234; rom[7]  = 16'hABCD;
      rom[8]  = 16'hDEAD; rom[9]  = 16'hBEEF;
      rom[10] = 16'h5555; rom[11] = 16'h6666;
      bus.fetch_req_i = 1'b0;
      bus.fetch_adr_i = '0;
      #1 reset_i = 1'b1;
      #1;
      chk("rst_ready", bus.fetch_ready_o, 1);
      chk("rst_valid", bus.fetch_valid_o, 0);
      chk("rst_err", bus.fetch_err_o, 0);
      chk("rst_dat", bus.fetch_dat_o, 0);
      chk("rst_cyc", bus.m_cyc_o, 0);
      chk("rst_stb", bus.m_stb_o, 0);
      chk("rst_adr", bus.m_adr_o, 0);
      chk("rst_we", bus.m_we_o, 0);
      @(negedge clk_i) reset_i = 1'b0;
      @(negedge clk_i);

      bus.fetch_req_i = 1'b1;
      bus.fetch_adr_i = 6'd0;
      @(negedge clk_i);
      bus.fetch_req_i = 1'b0;
      chk("zw_lo_adr", bus.m_adr_o, 0);
      chk("zw_lo_stb", bus.m_stb_o, 1);
      chk("zw_lo_cyc", bus.m_cyc_o, 1);
      chk("zw_busy", bus.fetch_ready_o, 0);
      chk("zw_no_valid", bus.fetch_valid_o, 0);
      @(negedge clk_i);
      chk("zw_hi_adr", bus.m_adr_o, 1);
      chk("zw_hi_stb", bus.m_stb_o, 1);
      @(negedge clk_i);
      chk("zw_valid", bus.fetch_valid_o, 1);
      chk("zw_dat", bus.fetch_dat_o, 32'h0000_0113);
      chk("zw_err", bus.fetch_err_o, 0);
      chk("zw_stb_drop", bus.m_stb_o, 0);
      chk("zw_adr_hold", bus.m_adr_o, 1);
      @(negedge clk_i);
      chk("zw_valid_drop", bus.fetch_valid_o, 0);
      chk("zw_ready", bus.fetch_ready_o, 1);

      a0 = acks;
      fetch(6'd1, 32'h0010_01B7, 1'b0, 2, 1'b1);
      fetch(6'd2, 32'h0011_0113, 1'b0, 2, 1'b1);
      chk("b2b_acks", acks - a0, 4);

      lo_wait = 3; hi_wait = 1;
      c0 = cyc_cyc;
      fetch(6'd3, 32'hABCD_1234, 1'b0, 6, 1'b0);
      chk("ws_cyc_cycles", cyc_cyc - c0, 6);
      lo_wait = 0;

      hi_wait = 100;
      s0 = stb_hi;
      fetch(6'd4, 32'h0, 1'b1, 5, 1'b0);
      chk("to_hi_stb_cycles", stb_hi - s0, 4);
      hi_wait = 0;
      fetch(6'd2, 32'h0011_0113, 1'b0, 2, 1'b0);

      lo_wait = 100;
      s0 = stb_hi;
      fetch(6'd4, 32'h0, 1'b1, 4, 1'b0);
      chk("to_lo_no_hi", stb_hi - s0, 0);
      lo_wait = 0;

      hi_wait = 100;
      v0 = vcnt;
      bus.fetch_req_i = 1'b1;
      bus.fetch_adr_i = 6'd5;
      @(negedge clk_i);
      bus.fetch_req_i = 1'b0;
      @(negedge clk_i);
      chk("mid_hi_stb", bus.m_stb_o, 1);
      chk("mid_hi_adr", bus.m_adr_o, 11);
      #1 reset_i = 1'b1;
      #1;
      chk("mid_rst_cyc", bus.m_cyc_o, 0);
      chk("mid_rst_stb", bus.m_stb_o, 0);
      chk("mid_rst_ready", bus.fetch_ready_o, 1);
      chk("mid_rst_adr", bus.m_adr_o, 0);
      @(negedge clk_i) reset_i = 1'b0;
      hi_wait = 0;
      repeat (3) @(negedge clk_i);
      chk("mid_rst_no_valid", vcnt - v0, 0);
      fetch(6'd5, 32'h6666_5555, 1'b0, 2, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
